// File: rtl/key_encoder8_3.sv
// Debounced 8-key priority encoder: reports the lowest-numbered pressed key.
// Latency: input sampled by sync1 at edge E -> stable at E+DB_CYCLES+1, outputs at E+DB_CYCLES+2.
// Backpressure: none; free-running, key_press is a one-cycle event pulse.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   key_n[7:0] asynchronous active-low key lines (bit i low = key i pressed)
//   code[2:0]  registered index of the highest-priority (lowest-numbered) pressed key
//   key_valid  registered, high while any debounced key is pressed
//   key_press  registered one-cycle pulse on each new code event
//   multi      registered, high while two or more debounced keys are pressed
module key_encoder8_3 #(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_n,
    output logic [2:0] code,
    output logic       key_valid,
    output logic       key_press,
    output logic       multi
);

    // The cycle that loads a new candidate already counts as the first
    // stable sample, so acceptance comes after DB_CYCLES equal samples of
    // sync2 rather than DB_CYCLES+1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 2);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESSED = 1'b1
    } state_t;

    logic [7:0]       sync1;
    logic [7:0]       sync2;
    logic [7:0]       candidate;
    logic [7:0]       stable;
    logic [CNT_W-1:0] cnt;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       code_nxt;
    logic             press_nxt;

    logic [2:0]       win;
    logic [3:0]       nzero;
    logic             any_pressed;

    // Synchronizer and debouncer. The counter saturates at CNT_LAST so a
    // long-held vector never wraps and re-triggers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 8'hFF;
            sync2     <= 8'hFF;
            candidate <= 8'hFF;
            stable    <= 8'hFF;
            cnt       <= '0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            if (sync2 != candidate) begin
                candidate <= sync2;
                cnt       <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= candidate;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Lowest-numbered low bit wins: scan from bit 7 down so bit 0 lands last.
    always_comb begin
        win = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!stable[i]) begin
                win = 3'(i);
            end
        end
    end

    always_comb begin
        nzero = 4'd0;
        for (int i = 0; i < 8; i++) begin
            nzero = nzero + {3'b000, ~stable[i]};
        end
    end

    assign any_pressed = (stable != 8'hFF);

    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        press_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (any_pressed) begin
                    code_nxt  = win;
                    press_nxt = 1'b1;
                    state_nxt = PRESSED;
                end
            end
            PRESSED: begin
                if (!any_pressed) begin
                    state_nxt = IDLE;
                end else if (win != code) begin
                    code_nxt  = win;
                    press_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            code      <= 3'd0;
            key_press <= 1'b0;
            key_valid <= 1'b0;
            multi     <= 1'b0;
        end else begin
            state     <= state_nxt;
            code      <= code_nxt;
            key_press <= press_nxt;
            key_valid <= any_pressed;
            multi     <= (nzero >= 4'd2);
        end
    end

endmodule

// File: tb/tb_key_encoder8_3.sv
// Directed bench for key_encoder8_3 with DB_CYCLES=4.
// Inputs change 2 time units after a rising edge; tick k after a change
// ends just after edge E+k-1, where E is the edge at which sync1 samples it.
// No flow control in the design under test.
module tb_key_encoder8_3;

    logic       clk;
    logic       rst;
    logic [7:0] key_n;
    logic [2:0] code;
    logic       key_valid;
    logic       key_press;
    logic       multi;

    int checks = 0;
    int errors = 0;

    key_encoder8_3 #(
        .DB_CYCLES(4),
        .CNT_W    (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_n    (key_n),
        .code     (code),
        .key_valid(key_valid),
        .key_press(key_press),
        .multi    (multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        int pulses;
        int vcnt;
        rst   = 1'b1;
        key_n = 8'hFF;
        tick();
        tick();
        checks++; if (code !== 3'd0) begin errors++; $display("FAIL reset_code got %0d want 0", code); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", key_valid); end
        checks++; if (key_press !== 1'b0) begin errors++; $display("FAIL reset_press got %b want 0", key_press); end
        checks++; if (multi !== 1'b0) begin errors++; $display("FAIL reset_multi got %b want 0", multi); end
        rst    = 1'b0;
        pulses = 0;
        vcnt   = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (key_press) pulses++;
            if (key_valid) vcnt++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL idle_pulses got %0d want 0", pulses); end
        checks++; if (vcnt !== 0) begin errors++; $display("FAIL idle_valid got %0d want 0", vcnt); end
    endtask

    task automatic test_single_key();
        int   pulses;
        int   first;
        logic v6;
        logic v7;
        key_n  = 8'hDF;
        pulses = 0;
        first  = 0;
        v6     = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (key_press) begin
                pulses++;
                if (first == 0) first = t;
            end
            if (t == 6) v6 = key_valid;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL single_pulses got %0d want 1", pulses); end
        checks++; if (first !== 7) begin errors++; $display("FAIL single_latency got tick %0d want 7", first); end
        checks++; if (v6 !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", v6); end
        checks++; if (code !== 3'd5) begin errors++; $display("FAIL single_code got %0d want 5", code); end
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", key_valid); end
        checks++; if (multi !== 1'b0) begin errors++; $display("FAIL single_multi got %b want 0", multi); end
        pulses = 0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (key_press) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL single_hold_pulses got %0d want 0", pulses); end
        key_n  = 8'hFF;
        pulses = 0;
        v6     = 1'b0;
        v7     = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (key_press) pulses++;
            if (t == 6) v6 = key_valid;
            if (t == 7) v7 = key_valid;
        end
        checks++; if (v6 !== 1'b1) begin errors++; $display("FAIL release_valid_early got %b want 1", v6); end
        checks++; if (v7 !== 1'b0) begin errors++; $display("FAIL release_valid got %b want 0", v7); end
        checks++; if (code !== 3'd5) begin errors++; $display("FAIL release_code got %0d want 5", code); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL release_pulses got %0d want 0", pulses); end
    endtask

    task automatic test_glitch();
        int pulses;
        int vcnt;
        key_n = 8'hF7;
        tick();
        tick();
        tick();
        key_n  = 8'hFF;
        pulses = 0;
        vcnt   = 0;
        for (int t = 1; t <= 15; t++) begin
            tick();
            if (key_press) pulses++;
            if (key_valid) vcnt++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", pulses); end
        checks++; if (vcnt !== 0) begin errors++; $display("FAIL glitch_valid got %0d want 0", vcnt); end
    endtask

    // A press lasting exactly DB_CYCLES samples is the shortest accepted one.
    task automatic test_min_width();
        int pulses;
        int first;
        key_n  = 8'hEF;
        pulses = 0;
        first  = 0;
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (t == 4) key_n = 8'hFF;
            if (key_press) begin
                pulses++;
                if (first == 0) first = t;
            end
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL minw_pulses got %0d want 1", pulses); end
        checks++; if (first !== 7) begin errors++; $display("FAIL minw_latency got tick %0d want 7", first); end
        checks++; if (code !== 3'd4) begin errors++; $display("FAIL minw_code got %0d want 4", code); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL minw_valid got %b want 0", key_valid); end
    endtask

    task automatic test_same_window();
        int pulses;
        key_n = 8'hF7;
        tick();
        tick();
        key_n  = 8'hF5;
        pulses = 0;
        for (int t = 1; t <= 14; t++) begin
            tick();
            if (key_press) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL window_pulses got %0d want 1", pulses); end
        checks++; if (code !== 3'd1) begin errors++; $display("FAIL window_code got %0d want 1", code); end
        checks++; if (multi !== 1'b1) begin errors++; $display("FAIL window_multi got %b want 1", multi); end
        key_n = 8'hFF;
        for (int t = 1; t <= 10; t++) tick();
    endtask

    task automatic test_multi();
        int pulses;
        int first;
        key_n  = 8'hB6;
        pulses = 0;
        first  = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (key_press) begin
                pulses++;
                if (first == 0) first = t;
            end
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL multi_pulses got %0d want 1", pulses); end
        checks++; if (first !== 7) begin errors++; $display("FAIL multi_latency got tick %0d want 7", first); end
        checks++; if (code !== 3'd0) begin errors++; $display("FAIL multi_code got %0d want 0", code); end
        checks++; if (multi !== 1'b1) begin errors++; $display("FAIL multi_flag got %b want 1", multi); end
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL multi_valid got %b want 1", key_valid); end
        key_n  = 8'hBF;
        pulses = 0;
        first  = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (key_press) begin
                pulses++;
                if (first == 0) first = t;
            end
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL remain_pulses got %0d want 1", pulses); end
        checks++; if (first !== 7) begin errors++; $display("FAIL remain_latency got tick %0d want 7", first); end
        checks++; if (code !== 3'd6) begin errors++; $display("FAIL remain_code got %0d want 6", code); end
        checks++; if (multi !== 1'b0) begin errors++; $display("FAIL remain_multi got %b want 0", multi); end
        key_n = 8'hFF;
        for (int t = 1; t <= 10; t++) tick();
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL multi_release_valid got %b want 0", key_valid); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        int first;
        key_n = 8'hFB;
        for (int t = 1; t <= 10; t++) tick();
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid got %b want 1", key_valid); end
        checks++; if (code !== 3'd2) begin errors++; $display("FAIL pre_rst_code got %0d want 2", code); end
        rst = 1'b1;
        tick();
        checks++; if (code !== 3'd0) begin errors++; $display("FAIL mid_rst_code got %0d want 0", code); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", key_valid); end
        checks++; if (key_press !== 1'b0) begin errors++; $display("FAIL mid_rst_press got %b want 0", key_press); end
        checks++; if (multi !== 1'b0) begin errors++; $display("FAIL mid_rst_multi got %b want 0", multi); end
        rst    = 1'b0;
        pulses = 0;
        first  = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (key_press) begin
                pulses++;
                if (first == 0) first = t;
            end
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL post_rst_pulses got %0d want 1", pulses); end
        checks++; if (first !== 7) begin errors++; $display("FAIL post_rst_latency got tick %0d want 7", first); end
        checks++; if (code !== 3'd2) begin errors++; $display("FAIL post_rst_code got %0d want 2", code); end
        key_n = 8'hFF;
        for (int t = 1; t <= 10; t++) tick();
    endtask

    initial begin
        rst   = 1'b1;
        key_n = 8'hFF;
        test_reset();
        test_single_key();
        test_glitch();
        test_min_width();
        test_same_window();
        test_multi();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
